// File: rtl/timer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// timer_ctrl_pkg
// Shared types and default widths for the timer control block.
//   state_e : FSM state encoding (IDLE / RUN / PAUSE), 2-bit
//   mode_e  : counting mode (one-shot / periodic)
//   cfg_t   : one complete timer configuration at the default widths
// ---------------------------------------------------------------------------
package timer_ctrl_pkg;

    localparam int TIMER_WIDTH     = 16;
    localparam int TIMER_PSC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    typedef struct packed {
        logic [TIMER_WIDTH-1:0]     period;
        logic [TIMER_PSC_WIDTH-1:0] psc;
        mode_e                      mode;
    } cfg_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_ctrl_if
// Control/status bundle between the core's register logic (master) and the
// timer control block (slave).
//
// Signalling: every input is a plain level sampled on each rising clock edge;
// there is no back-pressure. cfg_we_i is a write strobe that is accepted only
// while the block is IDLE and otherwise reported through a one-cycle
// cfg_err_o pulse the cycle after. start_i/stop_i are requests sampled every
// cycle (stop_i wins when both are high). tick_en_o and expire_o are
// combinational single-cycle pulses; irq_o/ovr_o are sticky until irq_ack_i.
//
// Signals:
//   cfg_we_i, cfg_period_i, cfg_psc_i, cfg_mode_i : configuration write
//   start_i, stop_i, irq_ack_i                    : control requests
//   busy_o, count_o, tick_en_o, expire_o          : timer status
//   irq_o, ovr_o, cfg_err_o                       : interrupt / error flags
//   dbg_state_o                                   : current FSM state
// ---------------------------------------------------------------------------
interface timer_ctrl_if
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH     = TIMER_WIDTH,
    parameter int PSC_WIDTH = TIMER_PSC_WIDTH
) ();

    logic                 cfg_we_i;
    logic [WIDTH-1:0]     cfg_period_i;
    logic [PSC_WIDTH-1:0] cfg_psc_i;
    logic                 cfg_mode_i;
    logic                 start_i;
    logic                 stop_i;
    logic                 irq_ack_i;

    logic                 busy_o;
    logic [WIDTH-1:0]     count_o;
    logic                 tick_en_o;
    logic                 expire_o;
    logic                 irq_o;
    logic                 ovr_o;
    logic                 cfg_err_o;
    state_e               dbg_state_o;

    modport master (
        output cfg_we_i, cfg_period_i, cfg_psc_i, cfg_mode_i,
        output start_i, stop_i, irq_ack_i,
        input  busy_o, count_o, tick_en_o, expire_o,
        input  irq_o, ovr_o, cfg_err_o, dbg_state_o
    );

    modport slave (
        input  cfg_we_i, cfg_period_i, cfg_psc_i, cfg_mode_i,
        input  start_i, stop_i, irq_ack_i,
        output busy_o, count_o, tick_en_o, expire_o,
        output irq_o, ovr_o, cfg_err_o, dbg_state_o
    );

endinterface

// File: rtl/timer_ctrl_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Divides the clock into a count-enable pulse: one tick every psc_i+1 cycles
// while run_i is high.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   psc_i          : divide value
//   run_i          : advance the prescale counter this cycle (held when low)
//   clear_i        : force the prescale counter back to 0
//   tick_en_o      : count-enable pulse (combinational from run_i/counter)
// ---------------------------------------------------------------------------
module timer_prescaler #(
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [PSC_WIDTH-1:0] psc_i,
    input  logic                 run_i,
    input  logic                 clear_i,
    output logic                 tick_en_o
);

    logic [PSC_WIDTH-1:0] psc_cnt_q;
    logic [PSC_WIDTH-1:0] psc_cnt_d;

    assign tick_en_o = run_i && (psc_cnt_q == psc_i);

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (clear_i) begin
            psc_cnt_d = '0;
        end else if (run_i) begin
            psc_cnt_d = tick_en_o ? '0 : psc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
// Control and sequencing for an up-counting timer: holds the configuration,
// sequences start/pause/resume/stop, owns the count register and raises a
// sticky interrupt with overrun detection on expiry.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   bus     : timer_ctrl_if.slave (config, start/stop/ack in; status out)
// ---------------------------------------------------------------------------
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH     = TIMER_WIDTH,
    parameter int PSC_WIDTH = TIMER_PSC_WIDTH
) (
    input logic         clk_i,
    input logic         rst_n_i,
    timer_ctrl_if.slave bus
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     period_q;
    logic [PSC_WIDTH-1:0] psc_q;
    mode_e                mode_q;
    logic                 irq_q, irq_d;
    logic                 ovr_q, ovr_d;
    logic                 cfg_err_q;

    logic run;
    logic clear;
    logic tick_en;
    logic at_period;
    logic expire;

    // stop_i in RUN freezes the prescaler in the same cycle, which is what
    // gives stop priority over a coincident tick/expiry.
    assign run   = (state_q == RUN) && !bus.stop_i;
    // Prescaler restarts from 0 on a fresh start and on a stop from PAUSE.
    assign clear = ((state_q == IDLE)  && bus.start_i && !bus.stop_i) ||
                   ((state_q == PAUSE) && bus.stop_i);

    timer_prescaler #(
        .PSC_WIDTH (PSC_WIDTH)
    ) u_prescaler (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .psc_i     (psc_q),
        .run_i     (run),
        .clear_i   (clear),
        .tick_en_o (tick_en)
    );

    assign at_period = (count_q == period_q);
    assign expire    = tick_en && at_period;

    // FSM next state and count register
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.stop_i) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                if (bus.stop_i) begin
                    state_d = PAUSE;
                end else if (tick_en) begin
                    if (at_period) begin
                        count_d = '0;
                        if (mode_q == MODE_ONESHOT) begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (bus.stop_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (bus.start_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Set beats acknowledge; overrun only latches when the pending irq is
    // not being acknowledged in the same cycle.
    always_comb begin
        irq_d = irq_q;
        ovr_d = ovr_q;
        if (expire) begin
            irq_d = 1'b1;
        end else if (bus.irq_ack_i) begin
            irq_d = 1'b0;
        end
        if (expire && irq_q && !bus.irq_ack_i) begin
            ovr_d = 1'b1;
        end else if (bus.irq_ack_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            irq_q     <= 1'b0;
            ovr_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
            ovr_q     <= ovr_d;
            cfg_err_q <= bus.cfg_we_i && (state_q != IDLE);
        end
    end

    // Configuration may only change while the timer is idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            period_q <= '1;
            psc_q    <= '0;
            mode_q   <= MODE_ONESHOT;
        end else if (bus.cfg_we_i && (state_q == IDLE)) begin
            period_q <= bus.cfg_period_i;
            psc_q    <= bus.cfg_psc_i;
            mode_q   <= mode_e'(bus.cfg_mode_i);
        end
    end

    assign bus.busy_o      = (state_q != IDLE);
    assign bus.count_o     = count_q;
    assign bus.tick_en_o   = tick_en;
    assign bus.expire_o    = expire;
    assign bus.irq_o       = irq_q;
    assign bus.ovr_o       = ovr_q;
    assign bus.cfg_err_o   = cfg_err_q;
    assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
// Directed bench for timer_ctrl. Stimulus pushes the cycle numbers at which
// expire_o and cfg_err_o pulses are due; a monitor on the falling edge pops
// and compares whenever the DUT raises either pulse. Level checks (count,
// busy, irq, ovr, state) are made 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;
    import timer_ctrl_pkg::*;

    localparam int W  = 16;
    localparam int PW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] exp_q[$];   // cycles where expire_o must pulse
    logic [31:0] err_q[$];   // cycles where cfg_err_o must pulse

    cfg_t vecs [0:4];

    timer_ctrl_if #(.WIDTH(W), .PSC_WIDTH(PW)) bus ();

    timer_ctrl #(.WIDTH(W), .PSC_WIDTH(PW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: pops an expectation whenever a pulse appears.
    always @(negedge clk) begin
        if (bus.expire_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL expire_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                chk("expire_cycle", 32'(cyc), exp_q.pop_front());
            end
        end
        if (bus.cfg_err_o === 1'b1) begin
            if (err_q.size() == 0) begin
                n_checks++;
                $display("FAIL cfg_err_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                chk("cfg_err_cycle", 32'(cyc), err_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input cfg_t c);
        bus.cfg_we_i     = 1'b1;
        bus.cfg_period_i = c.period;
        bus.cfg_psc_i    = c.psc;
        bus.cfg_mode_i   = c.mode;
        ticks(1);
        bus.cfg_we_i     = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start_i = 1'b1;
        ticks(1);
        bus.start_i = 1'b0;
    endtask

    task automatic ack_irq();
        bus.irq_ack_i = 1'b1;
        ticks(1);
        bus.irq_ack_i = 1'b0;
    endtask

    // From RUN: first cycle goes to PAUSE, second to IDLE.
    task automatic stop_to_idle();
        bus.stop_i = 1'b1;
        ticks(2);
        bus.stop_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;

        vecs[0] = '{period: 16'd3, psc: 8'd0, mode: MODE_ONESHOT};
        vecs[1] = '{period: 16'd2, psc: 8'd1, mode: MODE_PERIODIC};
        vecs[2] = '{period: 16'd9, psc: 8'd0, mode: MODE_PERIODIC};
        vecs[3] = '{period: 16'd0, psc: 8'd0, mode: MODE_PERIODIC};
        vecs[4] = '{period: 16'd5, psc: 8'd0, mode: MODE_PERIODIC};

        bus.cfg_we_i = 1'b0; bus.cfg_period_i = '0; bus.cfg_psc_i = '0;
        bus.cfg_mode_i = 1'b0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
        bus.irq_ack_i = 1'b0;

        ticks(3);
        rst_n = 1'b1;
        ticks(1);

        // Reset state
        chk("rst_busy",    32'(bus.busy_o),      32'd0);
        chk("rst_count",   32'(bus.count_o),     32'd0);
        chk("rst_tick",    32'(bus.tick_en_o),   32'd0);
        chk("rst_expire",  32'(bus.expire_o),    32'd0);
        chk("rst_irq",     32'(bus.irq_o),       32'd0);
        chk("rst_ovr",     32'(bus.ovr_o),       32'd0);
        chk("rst_cfg_err", 32'(bus.cfg_err_o),   32'd0);
        chk("rst_state",   32'(bus.dbg_state_o), 32'(IDLE));

        // One-shot: period 3, psc 0
        cfg_write(vecs[0]);
        c0 = cyc;
        exp_q.push_back(32'(c0 + 4));
        start_pulse();
        for (int i = 1; i <= 4; i++) begin
            chk("os_count", 32'(bus.count_o), 32'(i - 1));
            chk("os_busy",  32'(bus.busy_o),  32'd1);
            if (i < 4) ticks(1);
        end
        ticks(1);
        chk("os_idle_busy", 32'(bus.busy_o), 32'd0);
        chk("os_irq_set",   32'(bus.irq_o),  32'd1);
        ticks(2);
        chk("os_irq_held",  32'(bus.irq_o),  32'd1);
        ack_irq();
        chk("os_irq_ack",   32'(bus.irq_o),  32'd0);

        // Periodic with prescaler: period 2, psc 1
        cfg_write(vecs[1]);
        c0 = cyc;
        exp_q.push_back(32'(c0 + 6));
        exp_q.push_back(32'(c0 + 12));
        exp_q.push_back(32'(c0 + 18));
        start_pulse();
        for (int i = 1; i <= 18; i++) begin
            chk("per_tick", 32'(bus.tick_en_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("per_busy", 32'(bus.busy_o), 32'd1);
            if (i < 18) ticks(1);
        end
        ticks(1);
        stop_to_idle();
        chk("per_stop_busy", 32'(bus.busy_o), 32'd0);
        ack_irq();

        // Pause / resume: period 9, psc 0
        cfg_write(vecs[2]);
        c0 = cyc;
        exp_q.push_back(32'(c0 + 15));
        start_pulse();
        ticks(4);
        chk("pr_count_pre", 32'(bus.count_o), 32'd4);
        bus.stop_i = 1'b1;
        #1;
        chk("pr_stop_tick", 32'(bus.tick_en_o), 32'd0);
        ticks(1);
        bus.stop_i = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            chk("pr_hold_count", 32'(bus.count_o),     32'd4);
            chk("pr_hold_state", 32'(bus.dbg_state_o), 32'(PAUSE));
            chk("pr_hold_tick",  32'(bus.tick_en_o),   32'd0);
            if (i < 9) ticks(1);
        end
        start_pulse();
        chk("pr_resume_state", 32'(bus.dbg_state_o), 32'(RUN));
        chk("pr_resume_count", 32'(bus.count_o),     32'd4);
        ticks(1);
        chk("pr_resume_next",  32'(bus.count_o),     32'd5);
        ticks(5);
        stop_to_idle();
        ack_irq();
        chk("pr_irq_clear", 32'(bus.irq_o), 32'd0);

        // Overrun and acknowledge priority: period 0, psc 0
        cfg_write(vecs[3]);
        c0 = cyc;
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'(c0 + i));
        start_pulse();
        ticks(1);
        chk("ovr_irq_first",  32'(bus.irq_o), 32'd1);
        chk("ovr_clear_first", 32'(bus.ovr_o), 32'd0);
        ticks(1);
        chk("ovr_set",        32'(bus.ovr_o), 32'd1);
        bus.irq_ack_i = 1'b1;
        ticks(1);
        bus.irq_ack_i = 1'b0;
        chk("ack_vs_set_irq", 32'(bus.irq_o), 32'd1);
        chk("ack_vs_set_ovr", 32'(bus.ovr_o), 32'd0);
        ticks(1);
        chk("ovr_reset_again", 32'(bus.ovr_o), 32'd1);
        bus.stop_i = 1'b1;
        #1;
        chk("ovr_stop_expire", 32'(bus.expire_o), 32'd0);
        ticks(1);
        bus.stop_i = 1'b0;
        chk("ovr_pause_ovr", 32'(bus.ovr_o), 32'd1);
        ack_irq();
        chk("ack_idle_irq", 32'(bus.irq_o), 32'd0);
        chk("ack_idle_ovr", 32'(bus.ovr_o), 32'd0);
        bus.stop_i = 1'b1;
        ticks(1);
        bus.stop_i = 1'b0;
        chk("ovr_end_busy", 32'(bus.busy_o), 32'd0);

        // Config protection and stop priority: period 5, psc 0
        cfg_write(vecs[4]);
        c0 = cyc;
        exp_q.push_back(32'(c0 + 6));
        err_q.push_back(32'(c0 + 3));
        start_pulse();
        ticks(1);
        bus.cfg_we_i = 1'b1; bus.cfg_period_i = 16'd1; bus.cfg_mode_i = 1'b0;
        ticks(1);
        bus.cfg_we_i = 1'b0;
        ticks(4);
        chk("cp_still_busy", 32'(bus.busy_o),  32'd1);
        chk("cp_wrapped",    32'(bus.count_o), 32'd0);
        ticks(2);
        chk("cp_count",      32'(bus.count_o), 32'd2);
        bus.stop_i = 1'b1;
        ticks(1);
        chk("cp_pause_count", 32'(bus.count_o), 32'd2);
        chk("cp_pause_busy",  32'(bus.busy_o),  32'd1);
        ticks(1);
        bus.stop_i = 1'b0;
        chk("cp_stop_idle",  32'(bus.dbg_state_o), 32'(IDLE));
        chk("cp_stop_count", 32'(bus.count_o),     32'd0);
        bus.start_i = 1'b1; bus.stop_i = 1'b1;
        ticks(2);
        bus.start_i = 1'b0; bus.stop_i = 1'b0;
        chk("both_idle_busy", 32'(bus.busy_o), 32'd0);

        // Async reset mid-RUN, irq still pending from the previous expiry
        cfg_write(vecs[2]);
        start_pulse();
        ticks(5);
        chk("ar_count_pre", 32'(bus.count_o), 32'd5);
        chk("ar_irq_pre",   32'(bus.irq_o),   32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy",   32'(bus.busy_o),    32'd0);
        chk("ar_count",  32'(bus.count_o),   32'd0);
        chk("ar_irq",    32'(bus.irq_o),     32'd0);
        chk("ar_tick",   32'(bus.tick_en_o), 32'd0);
        chk("ar_ovr",    32'(bus.ovr_o),     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ticks(1);
        start_pulse();
        ticks(99);
        chk("ar_period_ones_count", 32'(bus.count_o), 32'd99);
        chk("ar_period_ones_busy",  32'(bus.busy_o),  32'd1);
        stop_to_idle();

        // Final report
        ticks(2);
        chk("expire_queue_empty",  32'(exp_q.size()), 32'd0);
        chk("cfg_err_queue_empty", 32'(err_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
